// File: rtl/lemmings_ctrl.sv
// Lemming walker Moore FSM; outputs are registered and follow the state one edge after the inputs. No flow control.
// Define LEMMINGS_SPLAT_EN to build in the fall counter and the terminal SPLAT state.
module lemmings_ctrl #(
    parameter int SPLAT_CYCLES = 20,
    parameter bit INIT_RIGHT   = 1'b0
) (
    input  logic clk,
    input  logic areset,
    input  logic bump_left,
    input  logic bump_right,
    input  logic ground,
    input  logic dig,
    output logic walk_left,
    output logic walk_right,
    output logic aaah,
    output logic digging,
    output logic splat
);

    typedef enum logic [2:0] {
        WALK_L = 3'd0,
        WALK_R = 3'd1,
        FALL_L = 3'd2,
        FALL_R = 3'd3,
        DIG_L  = 3'd4,
        DIG_R  = 3'd5,
        SPLAT  = 3'd6
    } state_t;

    localparam state_t RST_STATE = INIT_RIGHT ? WALK_R : WALK_L;

    state_t state_q, state_d;
    logic   splat_hit;
    logic   walk_left_q, walk_right_q, aaah_q, digging_q;

`ifdef LEMMINGS_SPLAT_EN
    localparam int CW = $clog2(SPLAT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SPLAT_CYCLES);

    logic [CW-1:0] fall_cnt_q, fall_cnt_d;
    logic          splat_q;

    // Counts void cycles after the first aaah cycle, so landing with
    // fall_cnt == SPLAT_CYCLES means SPLAT_CYCLES+1 cycles of aaah.
    always_comb begin
        fall_cnt_d = '0;
        if (state_q == FALL_L || state_q == FALL_R) begin
            fall_cnt_d = fall_cnt_q;
            if (!ground && fall_cnt_q != CNT_MAX) begin
                fall_cnt_d = fall_cnt_q + CW'(1);
            end
        end
    end

    assign splat_hit = (fall_cnt_q >= CNT_MAX);
`else
    assign splat_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            WALK_L: begin
                if (!ground)        state_d = FALL_L;
                else if (dig)       state_d = DIG_L;
                else if (bump_left) state_d = WALK_R;
            end
            WALK_R: begin
                if (!ground)         state_d = FALL_R;
                else if (dig)        state_d = DIG_R;
                else if (bump_right) state_d = WALK_L;
            end
            FALL_L: begin
                if (ground) state_d = splat_hit ? SPLAT : WALK_L;
            end
            FALL_R: begin
                if (ground) state_d = splat_hit ? SPLAT : WALK_R;
            end
            DIG_L: begin
                if (!ground) state_d = FALL_L;
            end
            DIG_R: begin
                if (!ground) state_d = FALL_R;
            end
`ifdef LEMMINGS_SPLAT_EN
            SPLAT:   state_d = SPLAT;
`endif
            default: state_d = WALK_L;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= RST_STATE;
            walk_left_q  <= !INIT_RIGHT;
            walk_right_q <= INIT_RIGHT;
            aaah_q       <= 1'b0;
            digging_q    <= 1'b0;
`ifdef LEMMINGS_SPLAT_EN
            splat_q      <= 1'b0;
            fall_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            walk_left_q  <= (state_d == WALK_L);
            walk_right_q <= (state_d == WALK_R);
            aaah_q       <= (state_d == FALL_L) || (state_d == FALL_R);
            digging_q    <= (state_d == DIG_L) || (state_d == DIG_R);
`ifdef LEMMINGS_SPLAT_EN
            splat_q      <= (state_d == SPLAT);
            fall_cnt_q   <= fall_cnt_d;
`endif
        end
    end

    assign walk_left  = walk_left_q;
    assign walk_right = walk_right_q;
    assign aaah       = aaah_q;
    assign digging    = digging_q;
`ifdef LEMMINGS_SPLAT_EN
    assign splat      = splat_q;
`else
    assign splat      = 1'b0;
`endif

endmodule

// File: tb/tb_lemmings_ctrl.sv
// Scoreboard bench for lemmings_ctrl: expected output vectors are queued as
// each cycle of stimulus is driven and compared one edge later.
module tb_lemmings_ctrl;

    logic clk = 1'b0;
    logic areset, bump_left, bump_right, ground, dig;
    logic walk_left, walk_right, aaah, digging, splat;
    logic [4:0] obs;

    int n_checks = 0;
    int n_errors = 0;
    logic [4:0] exp_q[$];

    // {walk_left, walk_right, aaah, digging, splat}
    localparam logic [4:0] WL = 5'b10000;
    localparam logic [4:0] WR = 5'b01000;
    localparam logic [4:0] AH = 5'b00100;
    localparam logic [4:0] DG = 5'b00010;
    localparam logic [4:0] SP = 5'b00001;

    lemmings_ctrl #(
        .SPLAT_CYCLES(20),
        .INIT_RIGHT  (1'b0)
    ) dut (
        .clk       (clk),
        .areset    (areset),
        .bump_left (bump_left),
        .bump_right(bump_right),
        .ground    (ground),
        .dig       (dig),
        .walk_left (walk_left),
        .walk_right(walk_right),
        .aaah      (aaah),
        .digging   (digging),
        .splat     (splat)
    );

    assign obs = {walk_left, walk_right, aaah, digging, splat};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b want %b (wl wr aaah dig splat)", tag, act, exp);
        end
    endtask

    task automatic step(input string tag, input logic g, input logic bl, input logic br,
                        input logic d, input logic [4:0] exp);
        logic [4:0] want;
        ground     = g;
        bump_left  = bl;
        bump_right = br;
        dig        = d;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check(tag, obs, want);
    endtask

    // Called just after an edge: reset lands between edges and must show at once.
    task automatic async_reset(input string tag);
        #2 areset = 1'b1;
        #1 check(tag, obs, WL);
        #1 areset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] r;
        areset = 1'b1; ground = 1'b1; bump_left = 1'b0; bump_right = 1'b0; dig = 1'b0;
        #3 check("reset_state", obs, WL);
        #5 areset = 1'b0;

        // Bumps and direction changes
        step("bl_pulse",     1, 1, 0, 0, WR);
        step("bl_release",   1, 0, 0, 0, WR);
        step("wr_ignore_bl", 1, 1, 0, 0, WR);
        step("both_bumps",   1, 1, 1, 0, WL);
        step("wl_ignore_br", 1, 0, 1, 0, WL);
        step("wl_bl_again",  1, 1, 0, 0, WR);

        // Five-cycle fall from WALK_R with bumps and dig toggling
        for (int i = 0; i < 5; i++) step("fall5", 0, i[0], ~i[0], (i == 2), AH);
        step("fall5_land", 1, 0, 0, 0, WR);

        // Dig to the right, fall out of the hole
        step("dig_r",      1, 0, 0, 1, DG);
        step("dig_r_hold", 1, 1, 1, 1, DG);
        step("dig_r_fall", 0, 0, 0, 0, AH);
        step("dig_r_land", 1, 0, 0, 0, WR);

        // Fall beats dig; dig ignores bumps; direction kept
        step("to_left",     1, 0, 1, 0, WL);
        step("dig_vs_fall", 0, 0, 0, 1, AH);
        step("dvf_land",    1, 0, 0, 0, WL);
        step("dig_l",       1, 0, 0, 1, DG);
        step("dig_l_bl",    1, 1, 0, 0, DG);
        step("dig_l_br",    1, 0, 1, 1, DG);
        step("dig_l_fall",  0, 0, 0, 0, AH);
        step("dig_l_land",  1, 0, 0, 0, WL);

        // Asynchronous reset mid-fall and mid-dig
        step("pre_rst",  1, 1, 0, 0, WR);
        step("rst_fall", 0, 0, 0, 0, AH);
        async_reset("async_rst_fall");
        step("post_rst_fall", 1, 0, 0, 0, WL);
        step("rst_dig", 1, 0, 0, 1, DG);
        async_reset("async_rst_dig");
        step("post_rst_dig", 1, 0, 0, 0, WL);

`ifdef LEMMINGS_SPLAT_EN
        for (int i = 0; i < 20; i++) step("fall20", 0, 0, 0, 0, AH);
        step("fall20_land", 1, 0, 0, 0, WL);
        for (int i = 0; i < 21; i++) step("fall21", 0, 0, 0, 0, AH);
        step("fall21_splat", 1, 0, 0, 0, SP);
        for (int i = 0; i < 8; i++) begin
            r = 4'($urandom_range(0, 15));
            step("splat_hold", r[0], r[1], r[2], r[3], SP);
        end
        async_reset("async_rst_splat");
        step("post_rst_splat", 1, 1, 0, 0, WR);
`else
        for (int i = 0; i < 100; i++) step("fall100", 0, i[1], i[2], i[0], AH);
        step("fall100_land", 1, 0, 0, 0, WL);
        step("post_fall100", 1, 1, 0, 0, WR);
`endif
        step("final_walk", 1, 0, 1, 0, WL);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
